iis_soft_mute: RTL and testbench

- Stereo soft-mute / gain-ramp stage directly downstream of the I2S receive port.
- Runs in the same sck domain and consumes the port's write_en strobe and left/right 32-bit samples.
- Applies a per-sample linear gain ramp between 0 and unity on mute/unmute requests from the register map, avoiding clicks.
- Presents the scaled samples with a one-cycle valid strobe to the ADSP input.

---
 rtl/iis_soft_mute.sv | 112 +++++++++++
 tb/tb_iis_soft_mute.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/iis_soft_mute.sv
// Stereo soft-mute stage: scales I2S sample pairs by a gain that ramps linearly
// between 0 and unity (Q1.15) whenever the mute request changes.
module iis_soft_mute #(
  parameter int GAIN_W = 16
) (
  input  logic              sck,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [31:0]       iis_adsp_left_data,
  input  logic [31:0]       iis_adsp_right_data,
  input  logic              regmap_mute_en,
  input  logic [7:0]        regmap_ramp_step,
  output logic              mute_out_valid,
  output logic [31:0]       mute_left_data,
  output logic [31:0]       mute_right_data,
  output logic [1:0]        mute_state,
  output logic [GAIN_W-1:0] mute_gain
);

  localparam int GE_W  = GAIN_W + 1;
  localparam int PR_W  = 32 + GE_W;
  localparam logic [GE_W-1:0] UNITY = GE_W'(1) << (GAIN_W - 1);

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    UNMUTED   = 2'd2,
    RAMP_DOWN = 2'd3
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [GAIN_W-1:0] gain_q;
  logic              valid_q;
  logic [31:0]       data_q [2];

  logic [GE_W-1:0]   gain_ext;
  logic [GE_W-1:0]   step_ext;
  logic [GE_W-1:0]   target;
  logic [GE_W-1:0]   sum_up;
  logic [GE_W-1:0]   gain_d;
  logic [31:0]       data_in [2];
  logic [31:0]       scaled  [2];

  // A zero step would freeze the ramp forever, so it is promoted to 1.
  assign gain_ext = {1'b0, gain_q};
  assign step_ext = (regmap_ramp_step == 8'd0) ? GE_W'(1) : GE_W'(regmap_ramp_step);
  assign target   = regmap_mute_en ? '0 : UNITY;
  assign sum_up   = gain_ext + step_ext;

  always_comb begin
    gain_d = gain_ext;
    if (gain_ext < target) begin
      gain_d = (sum_up > UNITY) ? UNITY : sum_up;
    end else if (gain_ext > target) begin
      gain_d = (gain_ext > step_ext) ? (gain_ext - step_ext) : '0;
    end
  end

  always_comb begin
    if ((gain_d == '0) && regmap_mute_en) begin
      state_d = MUTED;
    end else if ((gain_d == UNITY) && !regmap_mute_en) begin
      state_d = UNMUTED;
    end else if (gain_d < target) begin
      state_d = RAMP_UP;
    end else begin
      state_d = RAMP_DOWN;
    end
  end

  assign data_in[0] = iis_adsp_left_data;
  assign data_in[1] = iis_adsp_right_data;

  // Both channels use the gain held before this strobe; the arithmetic shift
  // truncates toward -inf, and gain <= unity means no saturation is required.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [PR_W-1:0] prod;
      assign prod       = PR_W'($signed(data_in[gi])) * PR_W'($signed(gain_ext));
      assign scaled[gi] = 32'(prod >>> (GAIN_W - 1));
    end
  endgenerate

  always_ff @(posedge sck) begin
    if (!rst_n) begin
      state_q <= MUTED;
      gain_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= write_en;
      if (write_en) begin
        state_q <= state_d;
        gain_q  <= gain_d[GAIN_W-1:0];
        for (int i = 0; i < 2; i++) begin
          data_q[i] <= scaled[i];
        end
      end
    end
  end

  assign mute_out_valid  = valid_q;
  assign mute_left_data  = data_q[0];
  assign mute_right_data = data_q[1];
  assign mute_state      = state_q;
  assign mute_gain       = gain_q;

endmodule

// File: tb/tb_iis_soft_mute.sv
// Bench for iis_soft_mute: directed ramp scenarios plus randomized traffic,
// all compared against a sample-level arithmetic model of the gain ramp.
module tb_iis_soft_mute;

  logic        sck = 1'b0;
  logic        rst_n;
  logic        write_en;
  logic [31:0] iis_adsp_left_data;
  logic [31:0] iis_adsp_right_data;
  logic        regmap_mute_en;
  logic [7:0]  regmap_ramp_step;
  logic        mute_out_valid;
  logic [31:0] mute_left_data;
  logic [31:0] mute_right_data;
  logic [1:0]  mute_state;
  logic [15:0] mute_gain;

  int checks   = 0;
  int failures = 0;

  int          m_gain  = 0;
  int          m_state = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_left  = '0;
  logic [31:0] m_right = '0;

  always #5 sck = ~sck;

  iis_soft_mute dut (
    .sck                 (sck),
    .rst_n               (rst_n),
    .write_en            (write_en),
    .iis_adsp_left_data  (iis_adsp_left_data),
    .iis_adsp_right_data (iis_adsp_right_data),
    .regmap_mute_en      (regmap_mute_en),
    .regmap_ramp_step    (regmap_ramp_step),
    .mute_out_valid      (mute_out_valid),
    .mute_left_data      (mute_left_data),
    .mute_right_data     (mute_right_data),
    .mute_state          (mute_state),
    .mute_gain           (mute_gain)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Sample * gain / 32768, rounded toward minus infinity.
  function automatic logic [31:0] ref_scale(input logic [31:0] s, input int g);
    longint p;
    p = longint'($signed(s)) * longint'(g);
    return 32'(p >>> 15);
  endfunction

  function automatic int ref_next_gain(input int g, input bit mute, input int stp);
    int t;
    int s;
    t = mute ? 0 : 32768;
    s = (stp == 0) ? 1 : stp;
    if (g < t) return (g + s > 32768) ? 32768 : g + s;
    if (g > t) return (g - s < 0) ? 0 : g - s;
    return g;
  endfunction

  function automatic int ref_state(input int g, input bit mute);
    if (mute && g == 0) return 0;
    if (!mute && g == 32768) return 2;
    if (g < (mute ? 0 : 32768)) return 1;
    return 3;
  endfunction

  // One sck cycle: drive inputs, advance the model at the edge, compare after it.
  task automatic xfer(input bit rst, input bit we, input bit mute, input int stp,
                      input logic [31:0] l, input logic [31:0] r);
    rst_n               = !rst;
    write_en            = we;
    regmap_mute_en      = mute;
    regmap_ramp_step    = 8'(stp);
    iis_adsp_left_data  = l;
    iis_adsp_right_data = r;
    @(posedge sck);
    if (rst) begin
      m_gain = 0; m_state = 0; m_valid = 1'b0; m_left = '0; m_right = '0;
    end else if (we) begin
      m_left  = ref_scale(l, m_gain);
      m_right = ref_scale(r, m_gain);
      m_gain  = ref_next_gain(m_gain, mute, stp);
      m_state = ref_state(m_gain, mute);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    #1;
    check_eq("valid", 64'(mute_out_valid), 64'(m_valid));
    check_eq("left",  64'(mute_left_data), 64'(m_left));
    check_eq("right", 64'(mute_right_data), 64'(m_right));
    check_eq("gain",  64'(mute_gain), 64'(m_gain));
    check_eq("state", 64'(mute_state), 64'(m_state));
    if (we || rst)
      $display("xfer rst=%0d we=%0d mute=%0d step=%0d l=%08h r=%08h -> v=%0d L=%08h R=%08h gain=%0d st=%0d",
               rst, we, mute, stp, l, r, mute_out_valid, mute_left_data, mute_right_data,
               mute_gain, mute_state);
  endtask

  task automatic strobes(input int n, input bit mute, input int stp,
                         input logic [31:0] l, input logic [31:0] r);
    for (int i = 0; i < n; i++) xfer(1'b0, 1'b1, mute, stp, l, r);
  endtask

  initial begin
    bit mute_r;
    int step_r;

    rst_n = 1'b0; write_en = 1'b0; regmap_mute_en = 1'b1; regmap_ramp_step = 8'd1;
    iis_adsp_left_data = '0; iis_adsp_right_data = '0;

    xfer(1'b1, 1'b0, 1'b1, 1, '0, '0);
    xfer(1'b1, 1'b0, 1'b1, 1, '0, '0);
    check_eq("reset_gain", 64'(mute_gain), 64'd0);
    check_eq("reset_valid", 64'(mute_out_valid), 64'd0);

    // Muted: outputs stay zero
    strobes(4, 1'b1, 1, 32'h40000000, 32'h40000000);
    check_eq("muted_left", 64'(mute_left_data), 64'd0);
    xfer(1'b0, 1'b0, 1'b1, 1, '0, '0);

    // Unmute ramp, step 128
    xfer(1'b0, 1'b1, 1'b0, 128, 32'h40000000, 32'hC0000000);
    check_eq("up_first_left", 64'(mute_left_data), 64'd0);
    xfer(1'b0, 1'b1, 1'b0, 128, 32'h40000000, 32'hC0000000);
    check_eq("up_second_left", 64'(mute_left_data), 64'h00400000);
    check_eq("up_second_right", 64'(mute_right_data), 64'hFFC00000);
    strobes(254, 1'b0, 128, 32'h40000000, 32'hC0000000);
    check_eq("up_end_gain", 64'(mute_gain), 64'd32768);
    check_eq("up_end_state", 64'(mute_state), 64'd2);
    strobes(2, 1'b0, 128, 32'h40000000, 32'hC0000000);
    check_eq("unity_left", 64'(mute_left_data), 64'h40000000);

    // Mute ramp, step 255
    xfer(1'b0, 1'b1, 1'b1, 255, 32'h12345678, 32'h87654321);
    check_eq("down_first_gain", 64'(mute_gain), 64'd32513);
    xfer(1'b0, 1'b1, 1'b1, 255, 32'h12345678, 32'h87654321);
    check_eq("down_second_gain", 64'(mute_gain), 64'd32258);
    strobes(126, 1'b1, 255, 32'h12345678, 32'h87654321);
    check_eq("down_last_gain", 64'(mute_gain), 64'd128);
    xfer(1'b0, 1'b1, 1'b1, 255, 32'h12345678, 32'h87654321);
    check_eq("down_end_gain", 64'(mute_gain), 64'd0);
    check_eq("down_end_state", 64'(mute_state), 64'd0);
    strobes(3, 1'b1, 255, 32'h7FFFFFFF, 32'h80000000);
    check_eq("muted_after_left", 64'(mute_left_data), 64'd0);

    // Reversal mid-ramp
    strobes(100, 1'b0, 128, 32'h01000000, 32'hFF000000);
    check_eq("rev_peak_gain", 64'(mute_gain), 64'd12800);
    xfer(1'b0, 1'b1, 1'b1, 128, 32'h01000000, 32'hFF000000);
    check_eq("rev_turn_gain", 64'(mute_gain), 64'd12672);
    check_eq("rev_turn_state", 64'(mute_state), 64'd3);
    strobes(99, 1'b1, 128, 32'h01000000, 32'hFF000000);
    check_eq("rev_end_gain", 64'(mute_gain), 64'd0);

    // Rounding at half gain, then step register 0
    strobes(128, 1'b0, 128, '0, '0);
    check_eq("half_gain", 64'(mute_gain), 64'd16384);
    xfer(1'b0, 1'b1, 1'b0, 128, 32'hFFFFFFFF, 32'h00000001);
    check_eq("round_neg1", 64'(mute_left_data), 64'hFFFFFFFF);
    check_eq("round_pos1", 64'(mute_right_data), 64'd0);
    xfer(1'b0, 1'b1, 1'b1, 128, '0, '0);
    xfer(1'b0, 1'b1, 1'b1, 128, 32'h80000000, '0);
    check_eq("round_min", 64'(mute_left_data), 64'hC0000000);
    xfer(1'b0, 1'b1, 1'b0, 0, '0, '0);
    check_eq("step0_gain", 64'(mute_gain), 64'd16257);
    xfer(1'b0, 1'b0, 1'b0, 0, 32'hDEADBEEF, '0);
    xfer(1'b0, 1'b1, 1'b0, 0, '0, '0);
    check_eq("step0_gain2", 64'(mute_gain), 64'd16258);

    // Reset during a ramp
    xfer(1'b1, 1'b0, 1'b1, 1, '0, '0);
    strobes(50, 1'b0, 128, 32'h40000000, 32'h40000000);
    check_eq("pre_rst_gain", 64'(mute_gain), 64'd6400);
    xfer(1'b1, 1'b1, 1'b0, 128, 32'h40000000, 32'h40000000);
    check_eq("rst_gain", 64'(mute_gain), 64'd0);
    check_eq("rst_data", 64'(mute_left_data), 64'd0);
    check_eq("rst_valid", 64'(mute_out_valid), 64'd0);
    xfer(1'b0, 1'b1, 1'b0, 128, 32'h40000000, 32'h40000000);
    check_eq("resume_gain", 64'(mute_gain), 64'd128);
    check_eq("resume_state", 64'(mute_state), 64'd1);

    // Randomized traffic
    mute_r = 1'b0;
    step_r = 200;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0) mute_r = ~mute_r;
      if ($urandom_range(0, 29) == 0) step_r = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 255);
      xfer($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, mute_r, step_r,
           $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
